// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage feeding the decode stage.
// Issues word reads to instruction memory, tracks in-flight requests
// with a credit scheme, and buffers returned words with their PC in a
// small FIFO. A redirect flushes the FIFO, marks in-flight responses for
// discard and restarts fetch at the new target.
// Optional build macro: FETCH_QUEUE_PERF_EN adds perf_fetched/perf_flushed.

module fetch_queue #(
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr
`ifdef FETCH_QUEUE_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);
   localparam logic [CNT_W:0] MAX_C   = (CNT_W + 1)'(MAX_OUTSTANDING);

   logic [31:0]      r_fetchPc;
   logic [31:0]      r_rspPc;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_outstanding;
   logic [CNT_W-1:0] r_discard;
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [31:0]      r_pcMem    [DEPTH];
   logic [31:0]      r_instrMem [DEPTH];

   logic [CNT_W:0]   w_credit;
   logic             w_issueOk;
   logic             w_reqFire;
   logic             w_rspLive;
   logic             w_push;
   logic             w_drop;
   logic             w_pop;
   logic [31:0]      w_redirTarget;
   logic [CNT_W-1:0] w_outAfterRsp;

   // Credit check counts buffered plus in-flight words so a response can never find the FIFO full.
   always_comb begin
      w_credit      = {1'b0, r_count} + {1'b0, r_outstanding};
      w_issueOk     = !redirect_valid && (w_credit < DEPTH_C) && ({1'b0, r_outstanding} < MAX_C);
      w_reqFire     = w_issueOk && mem_req_ready;
      w_rspLive     = mem_rsp_valid && (r_outstanding != '0);
      w_drop        = w_rspLive && (redirect_valid || (r_discard != '0));
      w_push        = w_rspLive && !redirect_valid && (r_discard == '0);
      w_pop         = out_valid && out_ready && !redirect_valid;
      w_redirTarget = redirect_pc & 32'hFFFF_FFFC;
      w_outAfterRsp = r_outstanding - CNT_W'(w_rspLive);
   end

   // Request and head outputs; the head is forced to zero while the FIFO is empty.
   always_comb begin
      mem_req_valid = w_issueOk && !reset;
      mem_req_addr  = r_fetchPc;
      out_valid     = (r_count != '0);
      out_pc        = out_valid ? r_pcMem[r_head]    : 32'h0;
      out_instr     = out_valid ? r_instrMem[r_head] : 32'h0;
   end

   // Fetch/response PCs, counters and FIFO pointers; a redirect overrides every other update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetchPc     <= RESET_PC;
         r_rspPc       <= RESET_PC;
         r_count       <= '0;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_head        <= '0;
         r_tail        <= '0;
      end else if (redirect_valid) begin
         r_fetchPc     <= w_redirTarget;
         r_rspPc       <= w_redirTarget;
         r_count       <= '0;
         r_head        <= '0;
         r_tail        <= '0;
         r_outstanding <= w_outAfterRsp;
         r_discard     <= w_outAfterRsp;
      end else begin
         if (w_reqFire) begin
            r_fetchPc <= r_fetchPc + 32'd4;
         end
         r_outstanding <= w_outAfterRsp + CNT_W'(w_reqFire);
         if (w_drop) begin
            r_discard <= r_discard - CNT_W'(1);
         end
         if (w_push) begin
            r_rspPc <= r_rspPc + 32'd4;
            r_tail  <= r_tail + PTR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage needs no reset since reads are gated by the entry count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pcMem[r_tail]    <= r_rspPc;
         r_instrMem[r_tail] <= mem_rsp_data;
      end
   end

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] r_perfFetched;
   logic [31:0] r_perfFlushed;
   logic [31:0] w_flushAdd;

   // Flushed work is every dropped response plus whatever the FIFO held when a redirect hit.
   always_comb begin
      w_flushAdd = (redirect_valid ? 32'(r_count) : 32'h0) + 32'(w_drop);
   end

   // Free-running event counters that wrap naturally at 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_perfFetched <= 32'h0;
         r_perfFlushed <= 32'h0;
      end else begin
         if (w_push) begin
            r_perfFetched <= r_perfFetched + 32'd1;
         end
         r_perfFlushed <= r_perfFlushed + w_flushAdd;
      end
   end

   assign perf_fetched = r_perfFetched;
   assign perf_flushed = r_perfFlushed;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue.
// A table of per-cycle input/expected-output records covers streaming,
// backpressure and a redirect with stale responses; hand-written sequences
// cover the remaining multi-cycle corner cases.

module tb_fetch_queue;

   logic        clk;
   logic        reset;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_flushed;
   logic [31:0] baseFetched;
   logic [31:0] baseFlushed;
`endif

   int checks;
   int errors;

   typedef struct {
      logic        reqReady;
      logic        rspValid;
      logic [31:0] rspData;
      logic        redirValid;
      logic [31:0] redirPc;
      logic        outReady;
      logic        expReqValid;
      logic [31:0] expReqAddr;
      logic        expOutValid;
      logic [31:0] expOutPc;
      logic [31:0] expOutInstr;
   } vec_t;

   vec_t vecs [18];

   fetch_queue #(
      .DEPTH(4),
      .MAX_OUTSTANDING(2),
      .RESET_PC(32'h0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_pc(out_pc),
      .out_instr(out_instr)
`ifdef FETCH_QUEUE_PERF_EN
      ,
      .perf_fetched(perf_fetched),
      .perf_flushed(perf_flushed)
`endif
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs at the falling edge and let outputs settle before checking.
   task automatic applyStimulus(input logic rdy, input logic rspV, input logic [31:0] data,
                                input logic redV, input logic [31:0] redPc, input logic oRdy);
      @(negedge clk);
      mem_req_ready  = rdy;
      mem_rsp_valid  = rspV;
      mem_rsp_data   = data;
      redirect_valid = redV;
      redirect_pc    = redPc;
      out_ready      = oRdy;
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Main test sequence.
   initial begin
      checks = 0;
      errors = 0;

      // Per cycle: rdy, rspV, rspData, redirV, redirPc, outRdy | reqV, addr, outV, outPc, outInstr
      vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h000, 1'b0, 32'h000, 32'h0};
      vecs[1]  = '{1'b1, 1'b1, 32'hD000_0000, 1'b0, 32'h0,   1'b1, 1'b1, 32'h004, 1'b0, 32'h000, 32'h0};
      vecs[2]  = '{1'b1, 1'b1, 32'hD000_0004, 1'b0, 32'h0,   1'b1, 1'b1, 32'h008, 1'b1, 32'h000, 32'hD000_0000};
      vecs[3]  = '{1'b1, 1'b1, 32'hD000_0008, 1'b0, 32'h0,   1'b1, 1'b1, 32'h00C, 1'b1, 32'h004, 32'hD000_0004};
      vecs[4]  = '{1'b1, 1'b1, 32'hD000_000C, 1'b0, 32'h0,   1'b1, 1'b1, 32'h010, 1'b1, 32'h008, 32'hD000_0008};
      vecs[5]  = '{1'b1, 1'b1, 32'hD000_0010, 1'b0, 32'h0,   1'b0, 1'b1, 32'h014, 1'b1, 32'h00C, 32'hD000_000C};
      vecs[6]  = '{1'b1, 1'b1, 32'hD000_0014, 1'b0, 32'h0,   1'b0, 1'b1, 32'h018, 1'b1, 32'h00C, 32'hD000_000C};
      vecs[7]  = '{1'b1, 1'b1, 32'hD000_0018, 1'b0, 32'h0,   1'b0, 1'b0, 32'h01C, 1'b1, 32'h00C, 32'hD000_000C};
      vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b0, 32'h01C, 1'b1, 32'h00C, 32'hD000_000C};
      vecs[9]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b0, 32'h01C, 1'b1, 32'h00C, 32'hD000_000C};
      vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h01C, 1'b1, 32'h010, 32'hD000_0010};
      vecs[11] = '{1'b1, 1'b1, 32'hD000_001C, 1'b0, 32'h0,   1'b1, 1'b1, 32'h020, 1'b1, 32'h014, 32'hD000_0014};
      vecs[12] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h024, 1'b1, 32'h018, 32'hD000_0018};
      vecs[13] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h103, 1'b1, 1'b0, 32'h028, 1'b1, 32'h01C, 32'hD000_001C};
      vecs[14] = '{1'b1, 1'b1, 32'hD000_0020, 1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 1'b0, 32'h000, 32'h0};
      vecs[15] = '{1'b1, 1'b1, 32'hD000_0024, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h000, 32'h0};
      vecs[16] = '{1'b1, 1'b1, 32'hD000_0100, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h000, 32'h0};
      vecs[17] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, 32'h100, 32'hD000_0100};

      reset          = 1'b1;
      mem_req_ready  = 1'b0;
      mem_rsp_valid  = 1'b0;
      mem_rsp_data   = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("rst.reqValid", 32'(mem_req_valid), 32'h0);
      checkOutput("rst.reqAddr",  mem_req_addr,        32'h0);
      checkOutput("rst.outValid", 32'(out_valid),     32'h0);
      checkOutput("rst.outPc",    out_pc,              32'h0);
      checkOutput("rst.outInstr", out_instr,           32'h0);
      reset = 1'b0;

      // Streaming, backpressure to a full FIFO, resume, then a redirect with two stale responses.
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].reqReady, vecs[i].rspValid, vecs[i].rspData,
                       vecs[i].redirValid, vecs[i].redirPc, vecs[i].outReady);
         checkOutput($sformatf("vec%0d.reqValid", i), 32'(mem_req_valid), 32'(vecs[i].expReqValid));
         checkOutput($sformatf("vec%0d.reqAddr", i),  mem_req_addr,        vecs[i].expReqAddr);
         checkOutput($sformatf("vec%0d.outValid", i), 32'(out_valid),     32'(vecs[i].expOutValid));
         checkOutput($sformatf("vec%0d.outPc", i),    out_pc,              vecs[i].expOutPc);
         checkOutput($sformatf("vec%0d.outInstr", i), out_instr,           vecs[i].expOutInstr);
      end

      // Redirect coinciding with a response and a pop: both are ignored and the FIFO empties.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("s4a.reqAddr", mem_req_addr, 32'h108);
      applyStimulus(1'b1, 1'b1, 32'hD000_0104, 1'b0, 32'h0, 1'b0);
      checkOutput("s4b.reqValid", 32'(mem_req_valid), 32'h0);
      applyStimulus(1'b1, 1'b1, 32'hD000_0108, 1'b1, 32'h200, 1'b1);
      checkOutput("s4c.reqValid", 32'(mem_req_valid), 32'h0);
      checkOutput("s4c.outValid", 32'(out_valid), 32'h1);
      checkOutput("s4c.outPc", out_pc, 32'h104);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("s4d.outValid", 32'(out_valid), 32'h0);
      checkOutput("s4d.outPc", out_pc, 32'h0);
      checkOutput("s4d.outInstr", out_instr, 32'h0);
      checkOutput("s4d.reqValid", 32'(mem_req_valid), 32'h1);
      checkOutput("s4d.reqAddr", mem_req_addr, 32'h200);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'hD000_0200, 1'b0, 32'h0, 1'b0);
      checkOutput("s4f.reqAddr", mem_req_addr, 32'h204);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("s4g.outValid", 32'(out_valid), 32'h1);
      checkOutput("s4g.outPc", out_pc, 32'h200);
      checkOutput("s4g.outInstr", out_instr, 32'hD000_0200);

      // Memory stalls for five cycles, then a redirect retargets without an extra request.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
         checkOutput($sformatf("s5.stall%0d.reqValid", i), 32'(mem_req_valid), 32'h1);
         checkOutput($sformatf("s5.stall%0d.reqAddr", i), mem_req_addr, 32'h204);
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
      checkOutput("s5.redir.reqValid", 32'(mem_req_valid), 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("s5.after.reqValid", 32'(mem_req_valid), 32'h1);
      checkOutput("s5.after.reqAddr", mem_req_addr, 32'h300);
      applyStimulus(1'b0, 1'b1, 32'hD000_0300, 1'b0, 32'h0, 1'b0);
      checkOutput("s5.next.reqAddr", mem_req_addr, 32'h304);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("s5.head.outValid", 32'(out_valid), 32'h1);
      checkOutput("s5.head.outPc", out_pc, 32'h300);
      checkOutput("s5.head.outInstr", out_instr, 32'hD000_0300);

      // Address wrap: unaligned target forced to FFFF_FFFC, next fetch wraps to zero.
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("s6.w2.reqAddr", mem_req_addr, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
      checkOutput("s6.w3.reqValid", 32'(mem_req_valid), 32'h1);
      checkOutput("s6.w3.reqAddr", mem_req_addr, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h9ABC_DEF0, 1'b0, 32'h0, 1'b0);
      checkOutput("s6.w4.outPc", out_pc, 32'hFFFF_FFFC);
      checkOutput("s6.w4.outInstr", out_instr, 32'h1234_5678);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("s6.w5.outPc", out_pc, 32'hFFFF_FFFC);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("s6.w6.outPc", out_pc, 32'h0);
      checkOutput("s6.w6.outInstr", out_instr, 32'h9ABC_DEF0);

      // Build three queued entries and flush them with one redirect.
`ifdef FETCH_QUEUE_PERF_EN
      baseFetched = perf_fetched;
      baseFlushed = perf_flushed;
`endif
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("p1.reqAddr", mem_req_addr, 32'h4);
      applyStimulus(1'b1, 1'b1, 32'h1111_0004, 1'b0, 32'h0, 1'b0);
      checkOutput("p2.reqValid", 32'(mem_req_valid), 32'h1);
      checkOutput("p2.reqAddr", mem_req_addr, 32'h8);
      applyStimulus(1'b0, 1'b1, 32'h1111_0008, 1'b0, 32'h0, 1'b0);
      checkOutput("p3.reqAddr", mem_req_addr, 32'hC);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0);
      checkOutput("p4.outPc", out_pc, 32'h0);
      checkOutput("p4.outInstr", out_instr, 32'h9ABC_DEF0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("p5.outValid", 32'(out_valid), 32'h0);
      checkOutput("p5.reqValid", 32'(mem_req_valid), 32'h1);
      checkOutput("p5.reqAddr", mem_req_addr, 32'h400);
`ifdef FETCH_QUEUE_PERF_EN
      checkOutput("perf.fetchedDelta", perf_fetched - baseFetched, 32'd2);
      checkOutput("perf.flushedDelta", perf_flushed - baseFlushed, 32'd3);
`endif

      // Reset asserted mid-operation clears the queue immediately.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'hD000_0400, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("mr.before.outPc", out_pc, 32'h400);
      reset = 1'b1;
      #1;
      checkOutput("mr.outValid", 32'(out_valid), 32'h0);
      checkOutput("mr.outPc", out_pc, 32'h0);
      checkOutput("mr.reqValid", 32'(mem_req_valid), 32'h0);
      checkOutput("mr.reqAddr", mem_req_addr, 32'h0);
`ifdef FETCH_QUEUE_PERF_EN
      checkOutput("mr.perfFetched", perf_fetched, 32'h0);
`endif
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
